// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
package pipe_pkg;

    // Default field widths used by the CPU datapath instances.
    localparam int CTRL_W_DEF = 8;
    localparam int DATA_W_DEF = 96;
    localparam int CNT_W_DEF  = 16;

    // One stage entry at the default widths: valid flag, control enables
    // (dREN, dWEN, regWr, ...) and the data payload (nPC, ALUOut, ...).
    typedef struct packed {
        logic                  valid;
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [DATA_W_DEF-1:0] data;
    } stage_ent_t;

endpackage

// File: rtl/pipe_slot.sv
// Single valid+ctrl+data holding register with load and flush.
// The control field is forced to zero whenever the held entry is invalid,
// so a bubble can never drive a memory enable or a register write.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Next-state: flush beats load; an invalid load writes a zero control field.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (CLR_DATA) begin
                data_d = '0;
            end
        end else if (load_i) begin
            valid_d = valid_i;
            ctrl_d  = valid_i ? ctrl_i : '0;
            data_d  = data_i;
        end
    end

    // Slot state register; reset always clears data regardless of CLR_DATA.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush,
// optional skid slot (registered in_ready) and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter bit SKID     = 1'b1,
    parameter bit CLR_DATA = 1'b0,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              clr_stats,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Inputs to the main (output-facing) slot, chosen by the mode logic below.
    logic              main_load;
    logic              main_v_in;
    logic [CTRL_W-1:0] main_c_in;
    logic [DATA_W-1:0] main_d_in;

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CLR_DATA (CLR_DATA)
    ) u_main (
        .CLK     (CLK),
        .RST     (RST),
        .flush_i (flush),
        .load_i  (main_load),
        .valid_i (main_v_in),
        .ctrl_i  (main_c_in),
        .data_i  (main_d_in),
        .valid_o (out_valid),
        .ctrl_o  (out_ctrl),
        .data_o  (out_data)
    );

    generate
        if (SKID) begin : g_skid
            logic              skid_valid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;
            logic              skid_load;
            logic              skid_v_in;
            logic [CTRL_W-1:0] skid_c_in;
            logic [DATA_W-1:0] skid_d_in;
            logic              main_take;

            pipe_slot #(
                .CTRL_W   (CTRL_W),
                .DATA_W   (DATA_W),
                .CLR_DATA (CLR_DATA)
            ) u_skid (
                .CLK     (CLK),
                .RST     (RST),
                .flush_i (flush),
                .load_i  (skid_load),
                .valid_i (skid_v_in),
                .ctrl_i  (skid_c_in),
                .data_i  (skid_d_in),
                .valid_o (skid_valid),
                .ctrl_o  (skid_ctrl),
                .data_o  (skid_data)
            );

            // Skid occupancy alone decides in_ready, so out_ready never
            // reaches in_ready combinationally.
            assign in_ready = ~skid_valid;

            // Main refills when empty or draining, from skid first to keep
            // FIFO order; otherwise an accepted input parks in the skid slot.
            always_comb begin
                main_take = ~out_valid | out_ready;
                main_load = main_take;
                main_v_in = skid_valid ? 1'b1      : in_valid;
                main_c_in = skid_valid ? skid_ctrl : in_ctrl;
                main_d_in = skid_valid ? skid_data : in_data;
                skid_load = 1'b0;
                skid_v_in = 1'b0;
                skid_c_in = '0;
                skid_d_in = skid_data;
                if (main_take) begin
                    // Entry moved to main: empty the skid slot, keep its data.
                    skid_load = skid_valid;
                end else if (in_valid & in_ready) begin
                    skid_load = 1'b1;
                    skid_v_in = 1'b1;
                    skid_c_in = in_ctrl;
                    skid_d_in = in_data;
                end
            end
        end else begin : g_noskid
            // Single slot: accept whenever the held entry is absent or leaving.
            assign in_ready = ~out_valid | out_ready;

            // Capture the input (possibly a bubble) on every ready cycle.
            always_comb begin
                main_load = in_ready;
                main_v_in = in_valid;
                main_c_in = in_ctrl;
                main_d_in = in_data;
            end
        end
    endgenerate

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Stall statistics: clear wins, otherwise count blocked outputs up to the max.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_stats) begin
            stall_cnt_d = '0;
        end else if (out_valid & ~out_ready & (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register; flush deliberately does not touch it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: a skid instance (CLR_DATA=0, 16-bit counter) and a
// single-slot instance (CLR_DATA=1, 3-bit counter) share one stimulus stream
// and are each compared against a FIFO-occupancy reference model.
module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 32;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          RST, flush, clr_stats, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          a_in_ready, a_out_valid;
    logic [CW-1:0] a_out_ctrl;
    logic [DW-1:0] a_out_data;
    logic [15:0]   a_stall;

    logic          b_in_ready, b_out_valid;
    logic [CW-1:0] b_out_ctrl;
    logic [DW-1:0] b_out_data;
    logic [2:0]    b_stall;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CLR_DATA(1'b0), .CNT_W(16)) dut_a (
        .CLK(CLK), .RST(RST), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
        .out_data(a_out_data), .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .CLR_DATA(1'b1), .CNT_W(3)) dut_b (
        .CLK(CLK), .RST(RST), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .stall_cnt(b_stall)
    );

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    int   sa, sb;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("a_out_valid", 64'(a_out_valid), 64'(qa.size() > 0));
        if (qa.size() > 0) begin
            chk("a_out_ctrl", 64'(a_out_ctrl), 64'(qa[0].c));
            chk("a_out_data", 64'(a_out_data), 64'(qa[0].d));
        end else begin
            chk("a_bubble_ctrl", 64'(a_out_ctrl), 64'd0);
        end
        chk("a_stall_cnt", 64'(a_stall), 64'(sa));
        chk("b_out_valid", 64'(b_out_valid), 64'(qb.size() > 0));
        if (qb.size() > 0) begin
            chk("b_out_ctrl", 64'(b_out_ctrl), 64'(qb[0].c));
            chk("b_out_data", 64'(b_out_data), 64'(qb[0].d));
        end else begin
            chk("b_bubble_ctrl", 64'(b_out_ctrl), 64'd0);
        end
        chk("b_stall_cnt", 64'(b_stall), 64'(sb));
    endtask

    // One clock cycle: drive at negedge, check ready, update model at posedge, check outputs.
    task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic fl, input logic clr);
        bit            ra, rb, fa, fb, ova, ovb, hav;
        logic [DW-1:0] hda;
        ent_t          e;
        @(negedge CLK);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        clr_stats = clr;
        #1;
        ra = (qa.size() < 2);
        rb = (qb.size() == 0) || ordy;
        chk("a_in_ready", 64'(a_in_ready), 64'(ra));
        chk("b_in_ready", 64'(b_in_ready), 64'(rb));
        fa  = v && ra;
        fb  = v && rb;
        ova = (qa.size() > 0);
        ovb = (qb.size() > 0);
        hav = ova;
        hda = ova ? qa[0].d : '0;
        @(posedge CLK);
        if (clr) sa = 0;
        else if (ova && !ordy && sa < 65535) sa++;
        if (clr) sb = 0;
        else if (ovb && !ordy && sb < 7) sb++;
        e.c = c;
        e.d = d;
        if (fl) begin
            qa.delete();
            qb.delete();
        end else begin
            if (ova && ordy) void'(qa.pop_front());
            if (fa) qa.push_back(e);
            if (ovb && ordy) void'(qb.pop_front());
            if (fb) qb.push_back(e);
        end
        #1;
        check_outputs();
        if (fl) begin
            if (hav) chk("a_flush_data_hold", 64'(a_out_data), 64'(hda));
            chk("b_flush_data_clr", 64'(b_out_data), 64'd0);
        end
    endtask

    // Asynchronous reset asserted between edges, checked before any clock edge.
    task automatic do_reset();
        #2;
        RST = 1'b1;
        #1;
        chk("rst_a_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("rst_a_data",  64'(a_out_data),  64'd0);
        chk("rst_a_stall", 64'(a_stall),     64'd0);
        chk("rst_b_valid", 64'(b_out_valid), 64'd0);
        chk("rst_b_ctrl",  64'(b_out_ctrl),  64'd0);
        chk("rst_b_stall", 64'(b_stall),     64'd0);
        qa.delete();
        qb.delete();
        sa = 0;
        sb = 0;
        @(negedge CLK);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        clr_stats = 1'b0;
        RST       = 1'b0;
        #1;
        chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    endtask

    initial begin
        logic          rv, ro, rf, rc;
        logic [CW-1:0] rcw;
        logic [DW-1:0] rdw;
        RST = 1'b0; flush = 1'b0; clr_stats = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_ctrl = '0; in_data = '0;
        sa = 0; sb = 0;
        do_reset();

        // Back-to-back streaming with the sink always ready.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, CW'(i + 1), DW'(32'hA000_0000 + i), 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Backpressure: fill main and skid, then release and drain.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, CW'(8'h20 + i), DW'(32'hB000_0000 + i), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        end

        // Flush while the skid slot is full, with an input offered the same cycle.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, CW'(8'h40 + i), DW'(32'hC000_0000 + i), 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 8'h5A, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Single-slot ready follows out_ready combinationally.
        step(1'b1, 8'h66, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        chk("b_rdy_blocked", 64'(b_in_ready), 64'(qb.size() == 0));
        out_ready = 1'b1;
        #1;
        chk("b_rdy_comb", 64'(b_in_ready), 64'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Saturation of the 3-bit counter, then clear together with a stall.
        step(1'b1, 8'h77, 32'h7777_0000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, CW'(8'h80 + i), DW'(32'h8000_0000 + i), 1'b0, 1'b0, 1'b0);
        end
        chk("b_stall_saturated", 64'(b_stall), 64'd7);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("b_stall_cleared", 64'(b_stall), 64'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional flush and statistics clear.
        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 3) != 0);
            ro  = ($urandom_range(0, 2) != 0);
            rf  = ($urandom_range(0, 39) == 0);
            rc  = ($urandom_range(0, 49) == 0);
            rcw = CW'($urandom);
            rdw = DW'($urandom);
            step(rv, rcw, rdw, ro, rf, rc);
        end

        // Reset asserted mid-stream while an entry is held.
        step(1'b1, 8'hF1, 32'hF1F1_F1F1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hF2, 32'hF2F2_F2F2, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'h3C, 32'h3C3C_3C3C, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
